// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential radix-2 restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DIV  = 2'b01,
    S_FIX  = 2'b10
  } state_t;

  // Step counter must hold values 0..width
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract.
module seq_divider_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] divisor_inv;
  logic [WIDTH:0] trial;

  // Carry chain built from generate/propagate terms; a - b computed as a + ~b + 1
  function automatic logic [WIDTH:0] cla_add(input logic [WIDTH:0] a,
                                             input logic [WIDTH:0] b,
                                             input logic cin);
    logic [WIDTH:0] g;
    logic [WIDTH:0] p;
    logic [WIDTH:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return p ^ c;
  endfunction

  always_comb begin
    shifted     = {rem, quo[WIDTH-1]};
    divisor_inv = ~{1'b0, divisor};
    trial       = cla_add(shifted, divisor_inv, 1'b1);
  end

  // Partial remainder stays below the divisor, so a negative trial leaves shifted within WIDTH bits
  assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned integer divider, one restoring step per clock.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  function automatic logic [WIDTH-1:0] neg_if(input logic en, input logic [WIDTH-1:0] v);
    return en ? (~v + WIDTH'(1)) : v;
  endfunction

  // MIN maps to itself under negation, which is exactly its unsigned magnitude
  function automatic logic [WIDTH-1:0] mag(input logic is_signed, input logic [WIDTH-1:0] v);
    return neg_if(is_signed & v[WIDTH-1], v);
  endfunction

  seq_divider_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (rem_nxt),
    .quo_next (quo_nxt)
  );

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            quo   <= mag(sgn, dividend);
            dvs   <= mag(sgn, divisor);
            rem   <= '0;
            cnt   <= '0;
            neg_q <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= sgn & dividend[WIDTH-1];
            dz    <= (divisor == '0);
            state <= (divisor == '0) ? S_FIX : S_DIV;
          end
        end
        S_DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          done        <= 1'b1;
          div_by_zero <= dz;
          if (dz) begin
            // quo still holds |dividend|; re-applying its sign restores the original operand
            quotient  <= '1;
            remainder <= neg_if(neg_r, quo);
          end else begin
            quotient  <= neg_if(neg_q, quo);
            remainder <= neg_if(neg_r, rem);
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed corner cases plus randomized operands in both modes.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sgn;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   kedge = 0;
  logic prev_done = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sgn         (sgn),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference uses native 32-bit arithmetic; truncating division matches the required sign rules
  function automatic exp_t ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   ia;
    int   ib;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.dz = 1'b1;
    end else if (s) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
      e.q = W'(ia / ib);
      e.r = W'(ia % ib);
      e.dz = 1'b0;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("state_legal", {31'b0, dut.state == 2'b11}, 0);
      if (done) begin
        check("busy_with_done", {31'b0, busy}, 0);
        check("done_one_cycle", {31'b0, prev_done}, 0);
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dz});
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    sgn      = s;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(ref_div(s, a, b));
    @(posedge clk);
    #1;
    kedge = cyc;
    start = 1'b0;
    check("busy_on_accept", {31'b0, busy}, 1);
  endtask

  task automatic wait_done(input int exp_lat);
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (!done) check("busy_while_running", {31'b0, busy}, 1);
    end
    if (!done) check("done_timeout", 0, 1);
    else check("latency", cyc - kedge, exp_lat);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    rst_n    = 1'b0;
    start    = 1'b0;
    sgn      = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dz", {31'b0, div_by_zero}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    launch(1'b0, 16'd100, 16'd7);            wait_done(W + 1);
    launch(1'b1, 16'hFF9C, 16'd7);           wait_done(W + 1);
    launch(1'b1, 16'd100, 16'hFFF9);         wait_done(W + 1);
    launch(1'b0, 16'h1234, 16'h0000);        wait_done(1);
    launch(1'b1, 16'h8000, 16'h0000);        wait_done(1);
    launch(1'b1, 16'h8000, 16'hFFFF);        wait_done(W + 1);
    launch(1'b0, 16'hFFFF, 16'h0001);        wait_done(W + 1);
    launch(1'b1, 16'h8000, 16'h0001);        wait_done(W + 1);

    // Held outputs must not move while idle with busy inputs toggling
    dividend = 16'h5555;
    divisor  = 16'h0003;
    sgn      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("hold_quotient", quotient, 16'h8000);
    check("hold_remainder", remainder, 16'h0000);

    // Start while busy is ignored
    launch(1'b0, 16'd1000, 16'd9);
    repeat (4) @(posedge clk);
    #1;
    sgn      = 1'b1;
    dividend = 16'd77;
    divisor  = 16'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(W + 1);
    // Start in the done cycle is accepted
    launch(1'b0, 16'd50, 16'd6);
    wait_done(W + 1);

    // Reset mid-divide discards the partial result
    launch(1'b0, 16'h1000, 16'd3);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_done", {31'b0, done}, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_dz", {31'b0, div_by_zero}, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("no_stale_done", {31'b0, done}, 0);
    end
    launch(1'b0, 16'd9, 16'd3);
    wait_done(W + 1);

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 1200; i++) begin
        a = W'($urandom);
        case ($urandom_range(0, 7))
          0:       b = '0;
          1:       b = ($urandom_range(0, 1) == 0) ? 16'h0001 : 16'hFFFF;
          2:       b = W'($urandom_range(1, 15));
          3:       begin a = 16'h8000; b = W'($urandom); end
          default: b = W'($urandom);
        endcase
        launch(s[0], a, b);
        wait_done((b == '0) ? 1 : W + 1);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
